// File: rtl/imem_responder.sv
// Word-addressed instruction store answering imem requests in order after a fixed latency.
// Fences squash in-flight reads and acknowledge with one mem_ready pulse after a timed flush.
package imem_pkg;
    typedef struct packed {
        logic        mem_valid;
        logic        mem_fence;
        logic        mem_instr;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
        logic [3:0]  mem_wstrb;
    } mem_in_type;

    typedef struct packed {
        logic [31:0] mem_rdata;
        logic        mem_ready;
    } mem_out_type;
endpackage

// state | meaning
// RUN   | accepting one read/write per cycle, responses flow out of the pipe
// FENCE | ignoring requests while the flush counter runs; ack when it reaches 0
module imem_responder
    import imem_pkg::*;
#(
    parameter int imem_depth   = 10,
    parameter int imem_latency = 2,
    parameter int fence_cycles = 4
) (
    input  logic        rst,
    input  logic        clk,
    input  mem_in_type  imem_in,
    output mem_out_type imem_out
);

    localparam int words = 1 << imem_depth;

    typedef enum logic {RUN, FENCE} state_t;

    state_t                  state;
    logic [3:0]              fence_cnt;
    logic [imem_latency-1:0] pipe_v;
    logic [31:0]             pipe_d [imem_latency];
    logic [31:0]             store  [words] = '{default: '0};

    logic [imem_depth-1:0]   idx;
    logic                    fence_req;
    logic                    accept;
    logic                    wr_req;
    logic                    unused_bits;

    assign idx       = imem_in.mem_addr[imem_depth+1:2];
    assign fence_req = (state == RUN) && imem_in.mem_valid && imem_in.mem_fence;
    assign accept    = (state == RUN) && imem_in.mem_valid && !imem_in.mem_fence;
    assign wr_req    = accept && (imem_in.mem_wstrb != 4'b0000);

    assign unused_bits = ^{imem_in.mem_instr, imem_in.mem_addr[31:imem_depth+2],
                           imem_in.mem_addr[1:0]};

    // Store has no reset: contents must survive a reset pulse.
    always_ff @(posedge clk) begin
        if (rst && wr_req) begin
            for (int b = 0; b < 4; b++) begin
                if (imem_in.mem_wstrb[b]) begin
                    store[idx][8*b +: 8] <= imem_in.mem_wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= RUN;
            fence_cnt <= 4'd0;
            pipe_v    <= '0;
            for (int i = 0; i < imem_latency; i++) begin
                pipe_d[i] <= '0;
            end
        end else begin
            case (state)
                RUN: begin
                    if (fence_req) begin
                        state     <= FENCE;
                        fence_cnt <= 4'(fence_cycles - 1);
                        pipe_v    <= '0;
                        for (int i = 0; i < imem_latency; i++) begin
                            pipe_d[i] <= '0;
                        end
                    end else begin
                        pipe_v[0] <= accept;
                        pipe_d[0] <= (accept && !wr_req) ? store[idx] : 32'h0;
                        for (int i = 1; i < imem_latency; i++) begin
                            pipe_v[i] <= pipe_v[i-1];
                            pipe_d[i] <= pipe_d[i-1];
                        end
                    end
                end
                FENCE: begin
                    pipe_v <= '0;
                    for (int i = 0; i < imem_latency; i++) begin
                        pipe_d[i] <= '0;
                    end
                    if (fence_cnt == 4'd0) begin
                        state <= RUN;
                    end else begin
                        fence_cnt <= fence_cnt - 4'd1;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    // Outputs depend only on registers; the fence ack is the only non-pipe source.
    assign imem_out.mem_ready = pipe_v[imem_latency-1] |
                                ((state == FENCE) && (fence_cnt == 4'd0));
    assign imem_out.mem_rdata = pipe_d[imem_latency-1];

endmodule

// File: tb/tb_imem_responder.sv
// Directed and random stimulus for imem_responder, checked each cycle against a
// schedule-based model of the response stream and a word-array model of the store.
module tb_imem_responder;
    import imem_pkg::*;

    localparam int DEPTH = 10;
    localparam int LAT   = 2;
    localparam int FC    = 4;
    localparam int MAXC  = 2048;
    localparam int WORDS = 1 << DEPTH;

    logic        clk;
    logic        rst;
    mem_in_type  imem_in;
    mem_out_type imem_out;

    imem_responder #(.imem_depth(DEPTH), .imem_latency(LAT), .fence_cycles(FC)) dut (
        .rst      (rst),
        .clk      (clk),
        .imem_in  (imem_in),
        .imem_out (imem_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    int          fence_end = -1;
    logic        exp_rdy [MAXC];
    logic [31:0] exp_dat [MAXC];
    logic [31:0] mm      [WORDS];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        total++;
        assert (got === expv) else begin
            bad++;
            $error("FAIL %s cycle=%0d got=%h expected=%h", tag, cyc, got, expv);
        end
    endtask

    task automatic clear_after(input int c);
        for (int i = c + 1; i < MAXC; i++) begin
            exp_rdy[i] = 1'b0;
            exp_dat[i] = 32'h0;
        end
    endtask

    // One clock cycle: check this cycle's outputs, drive this cycle's request, advance the model.
    task automatic do_cycle(input logic v, input logic f, input logic [31:0] a,
                            input logic [31:0] wd, input logic [3:0] ws);
        int w;
        @(posedge clk);
        #1;
        cyc++;
        chk("ready", {31'h0, imem_out.mem_ready}, {31'h0, exp_rdy[cyc]});
        chk("rdata", imem_out.mem_rdata, exp_dat[cyc]);
        imem_in.mem_valid = v;
        imem_in.mem_fence = f;
        imem_in.mem_instr = $urandom_range(0, 1);
        imem_in.mem_addr  = a;
        imem_in.mem_wdata = wd;
        imem_in.mem_wstrb = ws;
        if (v && cyc > fence_end) begin
            w = int'((a >> 2) % WORDS);
            if (f) begin
                clear_after(cyc);
                exp_rdy[cyc + FC] = 1'b1;
                exp_dat[cyc + FC] = 32'h0;
                fence_end = cyc + FC;
            end else begin
                exp_rdy[cyc + LAT] = 1'b1;
                if (ws != 4'b0000) begin
                    for (int b = 0; b < 4; b++)
                        if (ws[b]) mm[w][8*b +: 8] = wd[8*b +: 8];
                    exp_dat[cyc + LAT] = 32'h0;
                end else begin
                    exp_dat[cyc + LAT] = mm[w];
                end
            end
        end
    endtask

    task automatic rd(input logic [31:0] a);
        do_cycle(1'b1, 1'b0, a, $urandom, 4'b0000);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        do_cycle(1'b1, 1'b0, a, d, s);
    endtask

    task automatic fence();
        do_cycle(1'b1, 1'b1, $urandom, $urandom, 4'(($urandom_range(0, 1)) ? 4'hf : 4'h0));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) do_cycle(1'b0, 1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom));
    endtask

    initial begin
        int r;
        logic [31:0] a;
        for (int i = 0; i < MAXC; i++) begin exp_rdy[i] = 1'b0; exp_dat[i] = 32'h0; end
        for (int i = 0; i < WORDS; i++) mm[i] = 32'h0;
        imem_in = '0;
        rst = 1'b0;
        #1;
        chk("rst_ready", {31'h0, imem_out.mem_ready}, 32'h0);
        chk("rst_rdata", imem_out.mem_rdata, 32'h0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;

        // Writes, then back-to-back reads including an unaligned address
        wr(32'h0, 32'h0000_0013, 4'hf);
        wr(32'h4, 32'h00a0_0093, 4'hf);
        rd(32'h0);
        rd(32'h4);
        rd(32'h2);
        idle(3);

        // Byte-lane merge
        wr(32'h8, 32'hdead_beef, 4'hf);
        wr(32'h8, 32'h1122_3344, 4'b0101);
        rd(32'h8);
        idle(3);

        // Bubbles
        rd(32'h4);
        idle(1);
        rd(32'h8);
        idle(4);

        // Fence squash: requests during the fence are ignored, including a write
        rd(32'h0);
        rd(32'h4);
        fence();
        rd(32'h8);
        wr(32'hc, 32'hcafe_f00d, 4'hf);
        fence();
        rd(32'h0);
        rd(32'h4);
        idle(3);
        rd(32'hc);
        idle(3);

        // Fence held high across the acknowledge restarts a new fence
        for (int i = 0; i < FC + 3; i++) fence();
        idle(FC + 2);

        // Asynchronous reset with reads in flight
        rd(32'h0);
        rd(32'h4);
        #2;
        imem_in.mem_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk("async_rst_ready", {31'h0, imem_out.mem_ready}, 32'h0);
        clear_after(cyc);
        fence_end = -1;
        idle(3);
        #3 rst = 1'b1;
        idle(3);
        rd(32'h0);
        rd(32'h4);
        rd(32'h8);
        idle(3);

        // Wrap: upper address bits ignored
        rd(32'h0000_1000);
        rd(32'hffff_f008);
        idle(3);

        // Random traffic over a small window of words with random upper/low address bits
        for (int n = 0; n < 400; n++) begin
            a = ($urandom & 32'hffff_f000) | (32'($urandom_range(0, 15)) << 2) | ($urandom & 32'h3);
            r = $urandom_range(0, 99);
            if (r < 8)       fence();
            else if (r < 40) wr(a, $urandom, 4'($urandom_range(1, 15)));
            else if (r < 85) rd(a);
            else             idle(1);
        end
        idle(LAT + FC + 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
